temp_level_sampler: RTL and testbench
=====================================

// Module: temp_level_sampler
// PURPOSE
//  Polls a serial 12-bit temperature ADC, averages 2**AVG_LOG2 samples and quantises the mean into a
//  4-bit temperature code 4'b1010..4'b1111, with one-step hysteresis between levels.
//  Sits directly upstream of the temperature-to-colour decoder; temp_code drives its 4-bit input.
// PARAMETERS
//  CLK_DIV     4       clk cycles per adc_sclk half-period (>=2)
//  SAMPLE_GAP  100000  clk cycles idle between conversions (>=1)
//  AVG_LOG2    3       log2 of samples averaged per update (1..4)
//  THR_BASE    1200    T(0); thresholds T(k)=THR_BASE+k*THR_STEP, k=0..4 (12-bit counts)
//  THR_STEP    400     spacing between thresholds
//  HYST        16      hysteresis margin in ADC counts
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous, active-low reset
//  enable      in   1   1 = run conversions; 0 = idle after the current frame
//  adc_sdata   in   1   ADC serial data, MSB first
//  adc_cs_n    out  1   ADC chip select, active low
//  adc_sclk    out  1   ADC serial clock, idles high
//  temp_code   out  4   level code 4'b1010 (coldest) .. 4'b1111 (hottest), registered
//  code_valid  out  1   one-clk pulse each time temp_code is re-evaluated
//  sample_avg  out  12  last computed average, registered (debug)
// BEHAVIOUR
//  Reset (async, while reset_n=0): adc_cs_n=1, adc_sclk=1, temp_code=4'b1010, code_valid=0,
//   sample_avg=0, accumulator/sample count/gap counter=0, state=IDLE. Asserting mid-frame aborts it.
//  FSM: IDLE -> CONV -> ACC -> (UPDATE | IDLE); UPDATE -> IDLE.
//  IDLE: gap counter counts to SAMPLE_GAP-1; leave only if enable=1 at terminal count, else hold.
//   First conversion after reset/enable starts after a full gap.
//  CONV: adc_cs_n=0 on entry; adc_sclk toggles every CLK_DIV clks, first edge falling, CLK_DIV clks
//   after cs_n falls. adc_sdata sampled in the clk where adc_sclk goes 0->1; exactly 16 rising edges.
//   Bits[15:12] discarded, bits[11:0] = sample. After 16th rise, adc_sclk stays 1, cs_n rises
//   CLK_DIV clks later. enable dropping during CONV does not abort the frame.
//  ACC (1 clk): acc += sample (acc width 12+AVG_LOG2, no overflow); cnt++; cnt wraps to 0 at
//   2**AVG_LOG2 -> UPDATE, else IDLE.
//  UPDATE (1 clk): avg = acc >> AVG_LOG2 (truncate); sample_avg<=avg; acc<=0.
//   Level L = temp_code-4'b1010 (0..5). If L<5 and avg >= T(L)+HYST: L+1.
//   Else if L>0 and avg < T(L-1)-HYST: L-1. Else hold. One step per update max; saturate at 0/5.
//   Threshold arithmetic in 13+ bits; T(L-1)-HYST below 0 never triggers a step down.
//   temp_code and code_valid=1 registered together, visible the clk after UPDATE; pulse lasts 1 clk.
//  temp_code is always within 4'b1010..4'b1111; no other value is ever driven.
// STRUCTURE
//  Package temp_level_pkg: CODE_MIN=4'b1010, CODE_MAX=4'b1111, FSM state enum (IDLE,CONV,ACC,
//   UPDATE), threshold function thr(k).
//  Sub-module adc_serial_rx: cs_n/sclk generation + 16-bit shift; start in, done pulse + 12-bit
//   data out. Parent holds gap counter, accumulator, FSM, level logic.
// TESTING (bench ADC model drives adc_sdata on sclk falling edge; use SAMPLE_GAP=20)
//  1 Reset: reset_n=0 mid-CONV -> adc_cs_n=1, adc_sclk=1, temp_code=1010, code_valid=0 immediately.
//  2 Frame: model sends 16'hF123 -> 16 sclk rises per cs_n low; sample_avg=12'h123 after 8 frames.
//  3 Constant 12'h000 -> code_valid pulses every 8 frames; temp_code stays 1010.
//  4 Constant 12'hFFF -> temp_code 1011,1100,1101,1110,1111 on 5 successive updates, then holds 1111.
//  5 Hysteresis at 1010: avg 1215 -> 1010; 1216 -> 1011; 1184 -> 1011; 1183 -> 1010.
//  6 enable=0 during CONV -> frame completes, ACC runs, no new cs_n fall while enable=0; re-enable
//    -> next cs_n fall after SAMPLE_GAP clks; partial accumulation kept.

Source files
------------

// File: rtl/temp_level_pkg.sv
// Shared constants, FSM state type and threshold helper for the temperature level sampler.
package temp_level_pkg;

   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned FRAME_W  = 16;
   localparam int unsigned LEVEL_W  = 3;
   localparam int unsigned THR_W    = 15;

   localparam logic [3:0]         CODE_MIN  = 4'b1010;
   localparam logic [3:0]         CODE_MAX  = 4'b1111;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(CODE_MAX - CODE_MIN);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      ACC,
      UPDATE
   } state_e;

   // T(k) = base + k*step, widened so threshold +/- hysteresis never wraps
   function automatic logic [THR_W-1:0] thr(input logic [LEVEL_W-1:0] k,
                                            input int unsigned base,
                                            input int unsigned step);
      return THR_W'(base + 32'(k) * step);
   endfunction

endpackage

// File: rtl/temp_level_sampler_if.sv
// Serial ADC bus: chip select and clock from the sampler, data back from the converter.
interface temp_level_sampler_if;
   logic adc_cs_n;
   logic adc_sclk;
   logic adc_sdata;

   modport master (output adc_cs_n, output adc_sclk, input adc_sdata);
   modport slave  (input adc_cs_n, input adc_sclk, output adc_sdata);
endinterface

// File: rtl/temp_level_sampler_adc_serial_rx.sv
// Serial ADC frame engine: drives cs_n/sclk for one 16-clock frame and returns the low 12 data bits.
module adc_serial_rx
   import temp_level_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   temp_level_sampler_if.master    adc,
   output logic                    done,
   output logic [SAMPLE_W-1:0]     data
);

   localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TOG_W     = 6;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [TOG_W-1:0] TOG_LAST  = TOG_W'(2 * FRAME_W);

   logic             busy_q;
   logic [DIV_W-1:0] div_q;
   logic [TOG_W-1:0] tog_q;
   logic [SAMPLE_W-1:0] shift_q;

   // 32 sclk toggles, then one extra divider period before cs_n releases;
   // a 12-bit shifter naturally drops the four leading bits of the frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q       <= 1'b0;
         div_q        <= '0;
         tog_q        <= '0;
         shift_q      <= '0;
         adc.adc_cs_n <= 1'b1;
         adc.adc_sclk <= 1'b1;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!busy_q) begin
            if (start) begin
               busy_q       <= 1'b1;
               adc.adc_cs_n <= 1'b0;
               div_q        <= '0;
               tog_q        <= '0;
            end
         end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (tog_q == TOG_LAST) begin
               adc.adc_cs_n <= 1'b1;
               done         <= 1'b1;
               busy_q       <= 1'b0;
            end else begin
               adc.adc_sclk <= ~adc.adc_sclk;
               tog_q        <= tog_q + TOG_W'(1);
               if (!adc.adc_sclk) begin
                  shift_q <= {shift_q[SAMPLE_W-2:0], adc.adc_sdata};
               end
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   assign data = shift_q;

endmodule

// File: rtl/temp_level_sampler.sv
// Polls the serial temperature ADC, averages a block of samples and tracks a hysteretic level code.
module temp_level_sampler
   import temp_level_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned SAMPLE_GAP = 100000,
   parameter int unsigned AVG_LOG2   = 3,
   parameter int unsigned THR_BASE   = 1200,
   parameter int unsigned THR_STEP   = 400,
   parameter int unsigned HYST       = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   temp_level_sampler_if.master adc,
   output logic [3:0]           temp_code,
   output logic                 code_valid,
   output logic [SAMPLE_W-1:0]  sample_avg
);

   localparam int unsigned GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
   localparam int unsigned ACC_W = SAMPLE_W + AVG_LOG2;
   localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(SAMPLE_GAP - 1);
   localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

   state_e               state_q;
   state_e               state_d;
   logic [GAP_W-1:0]     gap_q;
   logic [ACC_W-1:0]     acc_q;
   logic [AVG_LOG2-1:0]  cnt_q;
   logic                 start_c;
   logic                 rx_done;
   logic [SAMPLE_W-1:0]  rx_data;
   logic [SAMPLE_W-1:0]  avg_c;
   logic [LEVEL_W-1:0]   lvl_c;
   logic [THR_W-1:0]     up_thr_c;
   logic [THR_W-1:0]     lo_thr_c;
   logic [3:0]           code_d_c;

   adc_serial_rx #(
      .CLK_DIV (CLK_DIV)
   ) u_rx (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start_c),
      .adc     (adc),
      .done    (rx_done),
      .data    (rx_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && gap_q == GAP_LAST) begin
               state_d = CONV;
               start_c = 1'b1;
            end
         end
         CONV:    if (rx_done) state_d = ACC;
         ACC:     state_d = (cnt_q == CNT_LAST) ? UPDATE : IDLE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Level step: at most one level per update, guarded against underflowing thresholds
   always_comb begin
      avg_c    = SAMPLE_W'(acc_q >> AVG_LOG2);
      lvl_c    = LEVEL_W'(temp_code - CODE_MIN);
      up_thr_c = thr(lvl_c, THR_BASE, THR_STEP) + THR_W'(HYST);
      lo_thr_c = thr(lvl_c - LEVEL_W'(1), THR_BASE, THR_STEP);
      code_d_c = temp_code;
      if (lvl_c < LEVEL_MAX && THR_W'(avg_c) >= up_thr_c) begin
         code_d_c = temp_code + 4'd1;
      end else if (lvl_c != '0 && lo_thr_c >= THR_W'(HYST) &&
                   THR_W'(avg_c) < lo_thr_c - THR_W'(HYST)) begin
         code_d_c = temp_code - 4'd1;
      end
   end

   // Gap counter restarts whenever the sampler is busy or disabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         temp_code  <= CODE_MIN;
         code_valid <= 1'b0;
         sample_avg <= '0;
      end else begin
         code_valid <= 1'b0;
         gap_q <= (state_q == IDLE && enable && gap_q != GAP_LAST) ? gap_q + GAP_W'(1) : '0;
         case (state_q)
            ACC: begin
               acc_q <= acc_q + ACC_W'(rx_data);
               cnt_q <= cnt_q + AVG_LOG2'(1);
            end
            UPDATE: begin
               acc_q      <= '0;
               sample_avg <= avg_c;
               temp_code  <= code_d_c;
               code_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_temp_level_sampler.sv
// Randomised bench for temp_level_sampler: serial ADC model plus block-average/level reference model.
module tb_temp_level_sampler;

   localparam int CLK_DIV    = 4;
   localparam int SAMPLE_GAP = 20;
   localparam int AVG_LOG2   = 3;
   localparam int NSAMP      = 1 << AVG_LOG2;
   localparam int THR_BASE   = 1200;
   localparam int THR_STEP   = 400;
   localparam int HYST       = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [3:0]  temp_code;
   logic        code_valid;
   logic [11:0] sample_avg;

   temp_level_sampler_if adc_if ();

   temp_level_sampler #(
      .CLK_DIV    (CLK_DIV),
      .SAMPLE_GAP (SAMPLE_GAP),
      .AVG_LOG2   (AVG_LOG2),
      .THR_BASE   (THR_BASE),
      .THR_STEP   (THR_STEP),
      .HYST       (HYST)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .adc        (adc_if.master),
      .temp_code  (temp_code),
      .code_valid (code_valid),
      .sample_avg (sample_avg)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ADC model: word latched at cs_n fall, one bit MSB-first on each sclk fall
   logic [15:0] adc_word = 16'h0;
   logic [15:0] cur_word;
   int          bitp;
   always @(negedge adc_if.adc_cs_n or negedge adc_if.adc_sclk) begin
      if (adc_if.adc_sclk === 1'b1) begin
         cur_word = adc_word;
         bitp     = 15;
      end else if (bitp >= 0) begin
         adc_if.adc_sdata = cur_word[bitp];
         bitp--;
      end
   end

   int rises = 0;
   always @(posedge adc_if.adc_sclk) if (adc_if.adc_cs_n === 1'b0) rises++;

   int          pulses = 0;
   logic [3:0]  cap_code;
   logic [11:0] cap_avg;
   always @(negedge clk) begin
      if (reset_n === 1'b1 && code_valid === 1'b1) begin
         pulses++;
         cap_code = temp_code;
         cap_avg  = sample_avg;
      end
   end

   // Reference: mean of each block of NSAMP samples, level moved by the threshold rules
   int q[$];
   int lvl_m   = 0;
   int exp_avg = 0;

   task automatic model_push(input int s, output bit upd);
      int sum;
      upd = 1'b0;
      q.push_back(s);
      if (q.size() == NSAMP) begin
         sum = 0;
         foreach (q[i]) sum += q[i];
         exp_avg = sum / NSAMP;
         q.delete();
         upd = 1'b1;
         if (lvl_m < 5 && exp_avg >= THR_BASE + lvl_m * THR_STEP + HYST) lvl_m++;
         else if (lvl_m > 0 && exp_avg < THR_BASE + (lvl_m - 1) * THR_STEP - HYST) lvl_m--;
      end
   endtask

   task automatic wait_cs(input logic lvl, input string tag);
      int n;
      n = 0;
      while (adc_if.adc_cs_n !== lvl && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (adc_if.adc_cs_n !== lvl) chk(tag, 32'(adc_if.adc_cs_n), 32'(lvl));
   endtask

   task automatic finish_frame(input logic [15:0] w, input int rs);
      int p0;
      bit upd;
      wait_cs(1'b1, "cs_rise_timeout");
      chk("sclk_rises", rises - rs, 16);
      chk("sclk_idle_high", 32'(adc_if.adc_sclk), 1);
      p0 = pulses;
      model_push(int'(w[11:0]), upd);
      repeat (6) @(negedge clk);
      chk("valid_pulses", pulses - p0, upd ? 1 : 0);
      if (upd) begin
         chk("temp_code", 32'(cap_code), 10 + lvl_m);
         chk("sample_avg", 32'(cap_avg), exp_avg);
      end
   endtask

   task automatic run_frame(input logic [15:0] w);
      int rs;
      adc_word = w;
      wait_cs(1'b0, "cs_fall_timeout");
      rs = rises;
      finish_frame(w, rs);
   endtask

   function automatic logic [15:0] mk_word(input int s);
      int c;
      c = (s < 0) ? 0 : ((s > 4095) ? 4095 : s);
      return {4'($urandom), 12'(c)};
   endfunction

   task automatic run_group(input int base, input int noise);
      for (int i = 0; i < NSAMP; i++) begin
         run_frame(mk_word(base + $urandom_range(0, 2 * noise) - noise));
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1);
   end

   initial begin
      logic [15:0] w;
      int rs;
      int n;
      reset_n = 1'b0;
      enable  = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(adc_if.adc_cs_n), 1);
      chk("rst_sclk", 32'(adc_if.adc_sclk), 1);
      chk("rst_code", 32'(temp_code), 32'hA);
      chk("rst_valid", 32'(code_valid), 0);
      chk("rst_avg", 32'(sample_avg), 0);
      reset_n = 1'b1;

      // Fixed frame pattern, then constant zero
      for (int i = 0; i < NSAMP; i++) run_frame(16'hF123);
      chk("avg_0x123", 32'(cap_avg), 32'h123);
      for (int g = 0; g < 2; g++) run_group(0, 0);
      chk("zero_code", 32'(temp_code), 32'hA);

      // Full scale climbs one level per update and saturates
      for (int g = 0; g < 6; g++) run_group(4095, 0);
      chk("sat_code", 32'(temp_code), 32'hF);

      // Reset in the middle of a frame
      adc_word = 16'hFABC;
      wait_cs(1'b0, "cs_fall_timeout");
      repeat (30) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_cs_n", 32'(adc_if.adc_cs_n), 1);
      chk("midrst_sclk", 32'(adc_if.adc_sclk), 1);
      chk("midrst_code", 32'(temp_code), 32'hA);
      chk("midrst_valid", 32'(code_valid), 0);
      q.delete();
      lvl_m = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Hysteresis around T(0)
      run_group(1215, 0);
      run_group(1216, 0);
      run_group(1184, 0);
      run_group(1183, 0);
      chk("hyst_final", 32'(temp_code), 32'hA);

      // Random means near thresholds
      for (int g = 0; g < 8; g++) begin
         run_group(THR_BASE + int'($urandom_range(0, 4)) * THR_STEP + int'($urandom_range(0, 64)) - 32, 6);
      end

      // Disable mid-frame: frame completes, partial block is kept
      for (int i = 0; i < 3; i++) run_frame(mk_word(int'($urandom_range(1000, 3000))));
      w = mk_word(int'($urandom_range(1000, 3000)));
      adc_word = w;
      wait_cs(1'b0, "cs_fall_timeout");
      rs = rises;
      repeat (10) @(negedge clk);
      enable = 1'b0;
      finish_frame(w, rs);
      n = 0;
      repeat (60) begin
         @(negedge clk);
         if (adc_if.adc_cs_n === 1'b0) n++;
      end
      chk("idle_while_disabled", n, 0);
      w = mk_word(int'($urandom_range(1000, 3000)));
      adc_word = w;
      @(posedge clk);
      #1;
      enable = 1'b1;
      n = 0;
      while (adc_if.adc_cs_n !== 1'b0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reenable_gap", n, SAMPLE_GAP);
      rs = rises;
      finish_frame(w, rs);
      for (int i = 0; i < 3; i++) run_frame(mk_word(int'($urandom_range(1000, 3000))));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
